// File: rtl/aes_pkg.sv
// Shared AES constants: block width and the legal range of buffer depths.
// Also sets the occupancy counter width exposed by the decrypt-side buffers.
package aes_pkg;
  localparam int AES_BLK_W = 128;
  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 16;
  localparam int CNT_W     = 5;
endpackage

// File: rtl/aes_blk_fifo.sv
// Circular store of 128-bit blocks with wrapping read/write pointers and occupancy count.
// Caller qualifies push/pop; storage is not reset, only pointers and count are.
import aes_pkg::*;

module aes_blk_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [AES_BLK_W-1:0] wdata_i,
  output logic [AES_BLK_W-1:0] rdata_o,
  output logic [CNT_W-1:0]     count_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [AES_BLK_W-1:0] mem_q [DEPTH];

  // DEPTH is a power of two, so pointer overflow is the wrap.
  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/dec_out_buffer.sv
// Plaintext output buffer after the final AES decryption round; one-cycle latency, full blocks input, sticky overflow.
// Define DEC_OUT_CBC_EN to XOR each block with the CBC chaining value before storing it.
import aes_pkg::*;

module dec_out_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] din,
  input  logic [AES_BLK_W-1:0] ct_in,
  input  logic                 iv_load,
  input  logic [AES_BLK_W-1:0] iv,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] dout,
  output logic [CNT_W-1:0]     count,
  output logic                 overflow
);

  logic                 push, pop;
  logic                 full, empty;
  logic                 overflow_q, overflow_d;
  logic [AES_BLK_W-1:0] wdata;

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

`ifdef DEC_OUT_CBC_EN
  logic [AES_BLK_W-1:0] chain_q, chain_d;
  logic [AES_BLK_W-1:0] chain_val;

  // A fresh IV takes effect for the block pushed in the same cycle.
  assign chain_val = iv_load ? iv : chain_q;
  assign wdata     = din ^ chain_val;

  always_comb begin
    chain_d = chain_q;
    if (push)         chain_d = ct_in;
    else if (iv_load) chain_d = iv;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) chain_q <= '0;
    else      chain_q <= chain_d;
  end
`else
  logic unused_chain_inputs;

  assign unused_chain_inputs = ^{ct_in, iv, iv_load};
  assign wdata               = din;
`endif

  // A block offered while full is dropped and latched as an error.
  assign overflow_d = overflow_q | (in_valid & full);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overflow_q <= 1'b0;
    else      overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;

  aes_blk_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wdata),
    .rdata_o (dout),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule

// File: tb/tb_dec_out_buffer.sv
// Directed bench for dec_out_buffer (DEPTH=4): reset, latency, full/overflow, streaming wrap, async reset.
// The CBC vector section is compiled only when DEC_OUT_CBC_EN is defined.
module tb_dec_out_buffer;
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] din;
  logic [127:0] ct_in;
  logic         iv_load;
  logic [127:0] iv;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] dout;
  logic [4:0]   count;
  logic         overflow;

  int checks   = 0;
  int failures = 0;

  dec_out_buffer #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .ct_in     (ct_in),
    .iv_load   (iv_load),
    .iv        (iv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] blk(input int i);
    logic [31:0] w;
    w = 32'(i) * 32'h0101_0101 + 32'h5A5A_0000;
    return {w, ~w, w ^ 32'hDEAD_BEEF, 32'(i)};
  endfunction

  initial begin
    logic [127:0] b [8];
    logic [127:0] s [22];
    rst = 1'b0; in_valid = 1'b0; din = '0; ct_in = '0;
    iv_load = 1'b0; iv = '0; out_ready = 1'b0;
    repeat (2) step();

    chk("rst_count", 128'(count), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_overflow", 128'(overflow), 128'd0);
    rst = 1'b1;
    step();

    // Single block, one-cycle latency
    in_valid = 1'b1; out_ready = 1'b1;
    din = 128'h00112233445566778899aabbccddeeff;
    step();
    in_valid = 1'b0;
    chk("lat_out_valid", 128'(out_valid), 128'd1);
    chk("lat_dout", dout, 128'h00112233445566778899aabbccddeeff);
    chk("lat_count", 128'(count), 128'd1);
    step();
    chk("pop_count", 128'(count), 128'd0);
    chk("pop_out_valid", 128'(out_valid), 128'd0);

    // Fill to DEPTH, then overflow
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) b[i] = blk(i + 100);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; din = b[i];
      step();
    end
    in_valid = 1'b0;
    chk("full_count", 128'(count), 128'd4);
    chk("full_in_ready", 128'(in_ready), 128'd0);
    chk("full_overflow", 128'(overflow), 128'd0);
    chk("full_head_stable", dout, b[0]);
    in_valid = 1'b1; din = b[4];
    step();
    in_valid = 1'b0;
    chk("ovf_set", 128'(overflow), 128'd1);
    chk("ovf_count", 128'(count), 128'd4);
    chk("ovf_head", dout, b[0]);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_%0d", i), dout, b[i]);
      step();
    end
    out_ready = 1'b0;
    chk("drain_count", 128'(count), 128'd0);
    chk("ovf_sticky", 128'(overflow), 128'd1);

    // Async reset with 3 entries, no clock edge needed
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; din = blk(i + 200);
      step();
    end
    in_valid = 1'b0;
    chk("pre_rst_count", 128'(count), 128'd3);
    rst = 1'b0;
    #2;
    chk("arst_count", 128'(count), 128'd0);
    chk("arst_out_valid", 128'(out_valid), 128'd0);
    chk("arst_overflow", 128'(overflow), 128'd0);
    chk("arst_in_ready", 128'(in_ready), 128'd1);
    step();
    rst = 1'b1;

    // Fresh fill after reset, then simultaneous push+pop while full
    for (int i = 0; i < 4; i++) begin
      b[i] = blk(i + 300);
      in_valid = 1'b1; din = b[i];
      step();
      if (i == 0) chk("post_rst_head", dout, b[0]);
    end
    chk("refill_count", 128'(count), 128'd4);
    in_valid = 1'b1; din = blk(399); out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("fullpp_count", 128'(count), 128'd3);
    chk("fullpp_overflow", 128'(overflow), 128'd1);
    chk("fullpp_head", dout, b[1]);
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("fullpp_drain_%0d", i), dout, b[i]);
      step();
    end
    out_ready = 1'b0;
    chk("fullpp_empty", 128'(out_valid), 128'd0);

    // Streaming at occupancy 2: pointers wrap several times
    for (int i = 0; i < 22; i++) s[i] = blk(i + 500);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; din = s[i];
      step();
    end
    for (int i = 2; i < 22; i++) begin
      in_valid = 1'b1; out_ready = 1'b1; din = s[i];
`ifndef DEC_OUT_CBC_EN
      iv_load = i[0]; iv = ~s[i]; ct_in = blk(i + 900);
`endif
      chk($sformatf("stream_dout_%0d", i - 2), dout, s[i - 2]);
      step();
      chk($sformatf("stream_count_%0d", i - 2), 128'(count), 128'd2);
    end
    in_valid = 1'b0; iv_load = 1'b0; iv = '0; ct_in = '0;
    for (int i = 20; i < 22; i++) begin
      chk($sformatf("stream_tail_%0d", i), dout, s[i]);
      step();
    end
    out_ready = 1'b0;
    chk("stream_end_count", 128'(count), 128'd0);

`ifdef DEC_OUT_CBC_EN
    begin
      logic [127:0] c [4];
      logic [127:0] p [4];
      logic [127:0] prev;
      c[0] = 128'h7649abac8119b246cee98e9b12e9197d;
      c[1] = 128'h5086cb9b507219ee95db113a917678b2;
      c[2] = 128'h73bed6b8e3c1743b7116e69e22229516;
      c[3] = 128'h3ff1caa1681fac09120eca307586e1a7;
      p[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
      p[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
      p[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
      p[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;
      iv_load = 1'b1; iv = 128'h000102030405060708090a0b0c0d0e0f;
      step();
      iv_load = 1'b0;
      prev = 128'h000102030405060708090a0b0c0d0e0f;
      for (int i = 0; i < 4; i++) begin
        in_valid = 1'b1; din = p[i] ^ prev; ct_in = c[i];
        prev = c[i];
        step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("cbc_pt_%0d", i + 1), dout, p[i]);
        step();
      end
      out_ready = 1'b0;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
